// File: rtl/fp_mul_seq_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fp_mul_seq_pkg: rounding modes, status bit indices, FSM states
// Rev 1.0
// ------------------------------------------------------------------
package fp_mul_seq_pkg;

  localparam logic [2:0] c_RND_RNE  = 3'd0;
  localparam logic [2:0] c_RND_RTZ  = 3'd1;
  localparam logic [2:0] c_RND_UP   = 3'd2;
  localparam logic [2:0] c_RND_DOWN = 3'd3;
  localparam logic [2:0] c_RND_NUP  = 3'd4;
  localparam logic [2:0] c_RND_AWAY = 3'd5;

  localparam int c_ST_ZERO    = 0;
  localparam int c_ST_INF     = 1;
  localparam int c_ST_INVALID = 2;
  localparam int c_ST_TINY    = 3;
  localparam int c_ST_HUGE    = 4;
  localparam int c_ST_INEXACT = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Modes 6 and 7 fall into the default arm and behave like away-from-zero.
  function automatic logic rnd_increment(input logic [2:0] rnd, input logic sign,
                                         input logic lsb, input logic guard,
                                         input logic sticky);
    logic r;
    case (rnd)
      c_RND_RNE:  r = guard & (sticky | lsb);
      c_RND_RTZ:  r = 1'b0;
      c_RND_UP:   r = ~sign & (guard | sticky);
      c_RND_DOWN: r = sign & (guard | sticky);
      c_RND_NUP:  r = guard;
      default:    r = guard | sticky;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mul_seq_round_pack.sv
`default_nettype none
// ------------------------------------------------------------------
// fp_mul_seq_round_pack: combinational round, overflow/underflow, pack
// Rev 1.0
// ------------------------------------------------------------------
module fp_mul_seq_round_pack
  import fp_mul_seq_pkg::*;
#(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8
) (
  input  logic                           i_sign,
  input  logic signed [EXP_WIDTH+1:0]    i_exp,
  input  logic        [SIG_WIDTH-1:0]    i_mant,
  input  logic                           i_guard,
  input  logic                           i_sticky,
  input  logic        [2:0]              i_rnd,
  input  logic                           i_zero,
  input  logic                           i_inf,
  output logic [SIG_WIDTH+EXP_WIDTH:0]   o_z,
  output logic [7:0]                     o_status
);

  localparam int EW2 = EXP_WIDTH + 2;
  localparam logic signed [EW2-1:0] c_EMAX = EW2'((2 ** EXP_WIDTH) - 1);

  logic                  w_inc;
  logic                  w_inexact;
  logic [SIG_WIDTH:0]    w_mant_r;
  logic signed [EW2-1:0] w_exp_r;
  logic                  w_huge;
  logic                  w_tiny;
  logic                  w_to_inf;
  logic                  w_to_min;

  assign w_inexact = i_guard | i_sticky;
  assign w_inc     = rnd_increment(i_rnd, i_sign, i_mant[0], i_guard, i_sticky);
  assign w_mant_r  = {1'b0, i_mant} + {{SIG_WIDTH{1'b0}}, w_inc};
  // A carry out of the fraction leaves it all-zero, so only the exponent moves.
  assign w_exp_r   = i_exp + EW2'(w_mant_r[SIG_WIDTH]);
  assign w_huge    = (w_exp_r >= c_EMAX);
  assign w_tiny    = w_exp_r[EW2-1] | (w_exp_r == '0);

  always_comb begin
    w_to_inf = 1'b1;
    w_to_min = 1'b0;
    case (i_rnd)
      c_RND_RNE, c_RND_NUP: begin
        w_to_inf = 1'b1;
        w_to_min = 1'b0;
      end
      c_RND_RTZ: begin
        w_to_inf = 1'b0;
        w_to_min = 1'b0;
      end
      c_RND_UP: begin
        w_to_inf = ~i_sign;
        w_to_min = ~i_sign;
      end
      c_RND_DOWN: begin
        w_to_inf = i_sign;
        w_to_min = i_sign;
      end
      default: begin
        w_to_inf = 1'b1;
        w_to_min = 1'b1;
      end
    endcase
  end

  always_comb begin
    o_z      = '0;
    o_status = '0;
    if (i_zero && i_inf) begin
      o_z                    = {1'b0, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
      o_status[c_ST_INVALID] = 1'b1;
    end else if (i_inf) begin
      o_z                = {i_sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
      o_status[c_ST_INF] = 1'b1;
    end else if (i_zero) begin
      o_z                 = {i_sign, {(EXP_WIDTH+SIG_WIDTH){1'b0}}};
      o_status[c_ST_ZERO] = 1'b1;
    end else if (w_huge) begin
      o_status[c_ST_HUGE]    = 1'b1;
      o_status[c_ST_INEXACT] = 1'b1;
      if (w_to_inf) begin
        o_z                = {i_sign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
        o_status[c_ST_INF] = 1'b1;
      end else begin
        o_z = {i_sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {SIG_WIDTH{1'b1}}};
      end
    end else if (w_tiny) begin
      o_status[c_ST_TINY]    = 1'b1;
      o_status[c_ST_INEXACT] = 1'b1;
      if (w_to_min) begin
        o_z = {i_sign, {(EXP_WIDTH-1){1'b0}}, 1'b1, {SIG_WIDTH{1'b0}}};
      end else begin
        o_z                 = {i_sign, {(EXP_WIDTH+SIG_WIDTH){1'b0}}};
        o_status[c_ST_ZERO] = 1'b1;
      end
    end else begin
      o_z                    = {i_sign, w_exp_r[EXP_WIDTH-1:0], w_mant_r[SIG_WIDTH-1:0]};
      o_status[c_ST_INEXACT] = w_inexact;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_mul_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// fp_mul_seq: sequential radix-2 shift-add IEEE-754 multiplier
// Rev 1.0
// ------------------------------------------------------------------
module fp_mul_seq
  import fp_mul_seq_pkg::*;
#(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] i_a,
  input  logic [SIG_WIDTH+EXP_WIDTH:0] i_b,
  input  logic [2:0]                   i_rnd,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [SIG_WIDTH+EXP_WIDTH:0] o_z,
  output logic [7:0]                   o_status
);

  localparam int ISIZE = SIG_WIDTH + EXP_WIDTH + 1;
  localparam int MW    = SIG_WIDTH + 1;
  localparam int PW    = 2 * MW;
  localparam int EW2   = EXP_WIDTH + 2;
  localparam int CW    = $clog2(SIG_WIDTH + 1);
  localparam logic [EW2-1:0] c_BIAS = EW2'((2 ** (EXP_WIDTH - 1)) - 1);

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [MW-1:0]         r_mcand;
  logic [PW-1:0]         r_acc;
  logic                  r_sign;
  logic signed [EW2-1:0] r_exp;
  logic                  r_zero;
  logic                  r_inf;
  logic [2:0]            r_rnd;
  logic [SIG_WIDTH-1:0]  r_mant;
  logic                  r_guard;
  logic                  r_sticky;
  logic                  r_out_valid;
  logic [ISIZE-1:0]      r_z;
  logic [7:0]            r_status;

  logic                  w_in_ready;
  logic                  w_accept;
  logic [EXP_WIDTH-1:0]  w_ea;
  logic [EXP_WIDTH-1:0]  w_eb;
  logic [EW2-1:0]        w_exp_sum;
  logic [MW:0]           w_sum;
  logic [ISIZE-1:0]      w_rp_z;
  logic [7:0]            w_rp_status;

  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && i_out_ready);
  assign w_accept   = i_in_valid && w_in_ready;
  assign w_ea       = i_a[ISIZE-2:SIG_WIDTH];
  assign w_eb       = i_b[ISIZE-2:SIG_WIDTH];
  assign w_exp_sum  = {2'b00, w_ea} + {2'b00, w_eb} - c_BIAS;
  // Multiplier sits in the low half of the accumulator and shifts out as the product shifts in.
  assign w_sum      = {1'b0, r_acc[PW-1:MW]} + (r_acc[0] ? {1'b0, r_mcand} : {(MW+1){1'b0}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_sign      <= 1'b0;
      r_exp       <= '0;
      r_zero      <= 1'b0;
      r_inf       <= 1'b0;
      r_rnd       <= '0;
      r_mant      <= '0;
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
      r_out_valid <= 1'b0;
      r_z         <= '0;
      r_status    <= '0;
    end else if (w_accept) begin
      r_state     <= S_MUL;
      r_cnt       <= CW'(SIG_WIDTH);
      r_mcand     <= {1'b1, i_a[SIG_WIDTH-1:0]};
      r_acc       <= {{MW{1'b0}}, 1'b1, i_b[SIG_WIDTH-1:0]};
      r_sign      <= i_a[ISIZE-1] ^ i_b[ISIZE-1];
      r_exp       <= w_exp_sum;
      r_zero      <= (w_ea == '0) || (w_eb == '0);
      r_inf       <= (&w_ea) || (&w_eb);
      r_rnd       <= i_rnd;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_MUL: begin
          r_acc <= {w_sum, r_acc[MW-1:1]};
          if (r_cnt == '0) begin
            r_state <= S_NORM;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_NORM: begin
          if (r_acc[PW-1]) begin
            r_mant   <= r_acc[PW-2 -: SIG_WIDTH];
            r_guard  <= r_acc[PW-2-SIG_WIDTH];
            r_sticky <= |r_acc[PW-3-SIG_WIDTH:0];
            r_exp    <= r_exp + EW2'(1);
          end else begin
            r_mant   <= r_acc[PW-3 -: SIG_WIDTH];
            r_guard  <= r_acc[PW-3-SIG_WIDTH];
            r_sticky <= |r_acc[PW-4-SIG_WIDTH:0];
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_z         <= w_rp_z;
          r_status    <= w_rp_status;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  fp_mul_seq_round_pack #(
    .SIG_WIDTH (SIG_WIDTH),
    .EXP_WIDTH (EXP_WIDTH)
  ) u_round_pack (
    .i_sign   (r_sign),
    .i_exp    (r_exp),
    .i_mant   (r_mant),
    .i_guard  (r_guard),
    .i_sticky (r_sticky),
    .i_rnd    (r_rnd),
    .i_zero   (r_zero),
    .i_inf    (r_inf),
    .o_z      (w_rp_z),
    .o_status (w_rp_status)
  );

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_z         = r_z;
  assign o_status    = r_status;

endmodule
`default_nettype wire
